serial_subtractor: RTL and testbench



---
 rtl/serial_sub_defs.sv | 12 +
 rtl/full_subtractor.sv | 16 +
 rtl/serial_subtractor.sv | 135 +++++++++++++
 tb/tb_serial_subtractor.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_sub_defs.sv
// Shared definitions for the bit-serial subtractor: state encoding and default width.
package serial_sub_defs;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: d = a - b - bi, with borrow-out bo.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bi,
  output logic d,
  output logic bo
);

  // Borrow is generated when a=0,b=1 and propagated when a==b.
  always_comb begin
    d  = a ^ b ^ bi;
    bo = (~a & b) | (~(a ^ b) & bi);
  end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor d = a - b - bin, LSB first, one bit per clock,
// behind valid/ready handshakes on both sides.
// Optional: define SERIAL_SUB_OVF_EN to add the signed overflow output ovf.
//
// state  | meaning
// IDLE   | waiting for operands, in_ready high
// RUN    | shifting one bit per cycle through the cell
// DONE   | result held on d/bout with out_valid until out_ready
module serial_subtractor
  import serial_sub_defs::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] d,
  output logic             bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CNT_W = $clog2(WIDTH);

  state_t             state;
  state_t             state_nxt;
  logic [WIDTH-1:0]   a_sr;
  logic [WIDTH-1:0]   b_sr;
  logic [WIDTH-1:0]   res_sr;
  logic [CNT_W-1:0]   cnt;
  logic               brw;
  logic               cell_d;
  logic               cell_bo;
  logic               last_bit;

`ifdef SERIAL_SUB_OVF_EN
  logic               a_msb;
  logic               b_msb;
`endif

  assign last_bit = (cnt == CNT_W'(WIDTH - 1));

  full_subtractor u_cell (
    .a  (a_sr[0]),
    .b  (b_sr[0]),
    .bi (brw),
    .d  (cell_d),
    .bo (cell_bo)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state and handshake outputs decoded from the current state.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = S_RUN;
      end
      S_RUN: begin
        if (last_bit) state_nxt = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Operand capture, bit-serial shifting, and result publication on the last bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      cnt    <= '0;
      brw    <= 1'b0;
      d      <= '0;
      bout   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
      ovf    <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            a_sr <= a;
            b_sr <= b;
            brw  <= bin;
            cnt  <= '0;
`ifdef SERIAL_SUB_OVF_EN
            a_msb <= a[WIDTH-1];
            b_msb <= b[WIDTH-1];
`endif
          end
        end
        S_RUN: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          res_sr <= {cell_d, res_sr[WIDTH-1:1]};
          brw    <= cell_bo;
          cnt    <= cnt + CNT_W'(1);
          // d/bout only move here so consumers never see partial results.
          if (last_bit) begin
            d    <= {cell_d, res_sr[WIDTH-1:1]};
            bout <= cell_bo;
`ifdef SERIAL_SUB_OVF_EN
            ovf  <= (a_msb ^ b_msb) & (a_msb ^ cell_d);
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=4): vector table,
// randomized operands against an arithmetic model, backpressure and reset cases.
module tb_serial_subtractor;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] d;
  logic         bout;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;
`endif

  serial_subtractor #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .d         (d),
    .bout      (bout)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic [W-1:0] ed;
    logic         eb;
  } vec_t;

  vec_t         vecs[8];
  int           n_pass  = 0;
  int           n_total = 0;
  logic [W-1:0] last_d  = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference: plain integer subtraction; borrow means the true result is negative.
  function automatic int ref_diff(input logic [W-1:0] x, input logic [W-1:0] y, input logic bi);
    return int'(x) - int'(y) - int'(bi);
  endfunction

  // Signed overflow of x - y in W-bit two's complement (borrow-in 0).
  function automatic logic ref_ovf(input logic [W-1:0] x, input logic [W-1:0] y);
    int sx, sy, r;
    sx = x[W-1] ? int'(x) - (1 << W) : int'(x);
    sy = y[W-1] ? int'(y) - (1 << W) : int'(y);
    r  = sx - sy;
    return (r < -(1 << (W - 1))) || (r > (1 << (W - 1)) - 1);
  endfunction

  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tbin,
                        output logic [W-1:0] rd, output logic rb, output logic rovf,
                        output int lat);
    int guard;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(posedge clk); #1; guard++;
    end
    check("in_ready_idle", 32'(in_ready), 32'd1);
    a = ta; b = tb; bin = tbin; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
    lat = 1;
    while (!out_valid && lat < 40) begin
      check("d_hold_run", 32'(d), 32'(last_d));
      check("in_ready_run", 32'(in_ready), 32'd0);
      @(posedge clk); #1; lat++;
    end
    rd = d; rb = bout;
`ifdef SERIAL_SUB_OVF_EN
    rovf = ovf;
`else
    rovf = 1'b0;
`endif
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("out_valid_drop", 32'(out_valid), 32'd0);
    last_d = rd;
  endtask

  initial begin
    logic [W-1:0] rd, ra, rb_op;
    logic         rb, rovf, rbin;
    int           lat, ex, guard;

    vecs[0] = '{a: 4'd9,  b: 4'd3,  bin: 1'b0, ed: 4'd6,  eb: 1'b0};
    vecs[1] = '{a: 4'd3,  b: 4'd9,  bin: 1'b0, ed: 4'hA,  eb: 1'b1};
    vecs[2] = '{a: 4'd0,  b: 4'd0,  bin: 1'b1, ed: 4'hF,  eb: 1'b1};
    vecs[3] = '{a: 4'hF,  b: 4'hF,  bin: 1'b1, ed: 4'hF,  eb: 1'b1};
    vecs[4] = '{a: 4'hF,  b: 4'h0,  bin: 1'b0, ed: 4'hF,  eb: 1'b0};
    vecs[5] = '{a: 4'h8,  b: 4'h7,  bin: 1'b1, ed: 4'h0,  eb: 1'b0};
    vecs[6] = '{a: 4'h7,  b: 4'hF,  bin: 1'b0, ed: 4'h8,  eb: 1'b1};
    vecs[7] = '{a: 4'h5,  b: 4'h2,  bin: 1'b0, ed: 4'h3,  eb: 1'b0};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; bin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_d", 32'(d), 32'd0);
    check("rst_bout", 32'(bout), 32'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // Directed vector table
    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].bin, rd, rb, rovf, lat);
      check("vec_latency", 32'(lat), 32'(W + 1));
      check("vec_d", 32'(rd), 32'(vecs[i].ed));
      check("vec_bout", 32'(rb), 32'(vecs[i].eb));
`ifdef SERIAL_SUB_OVF_EN
      if (vecs[i].bin == 1'b0) check("vec_ovf", 32'(rovf), 32'(ref_ovf(vecs[i].a, vecs[i].b)));
`endif
    end

    // Randomized operands against the arithmetic model
    for (int i = 0; i < 30; i++) begin
      ra = W'($urandom); rb_op = W'($urandom); rbin = 1'($urandom);
      run_op(ra, rb_op, rbin, rd, rb, rovf, lat);
      ex = ref_diff(ra, rb_op, rbin);
      check("rnd_latency", 32'(lat), 32'(W + 1));
      check("rnd_d", 32'(rd), 32'(ex & ((1 << W) - 1)));
      check("rnd_bout", 32'(rb), 32'(ex < 0));
`ifdef SERIAL_SUB_OVF_EN
      if (rbin == 1'b0) check("rnd_ovf", 32'(rovf), 32'(ref_ovf(ra, rb_op)));
`endif
    end

    // Backpressure: result held while out_ready is low; in_valid pulses ignored
    a = 4'd9; b = 4'd3; bin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    guard = 0;
    while (!out_valid && guard < 40) begin
      @(posedge clk); #1; guard++;
    end
    check("bp_valid_seen", 32'(out_valid), 32'd1);
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0]; a = W'($urandom); b = W'($urandom);
      @(posedge clk); #1;
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_d", 32'(d), 32'd6);
      check("bp_bout", 32'(bout), 32'd0);
      check("bp_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_release", 32'(out_valid), 32'd0);
    check("bp_idle", 32'(in_ready), 32'd1);

    // Reset during the second RUN cycle discards the operation
    a = 4'd9; b = 4'd3; bin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_d", 32'(d), 32'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    check("post_rst_d", 32'(d), 32'd0);
    last_d = '0;
    run_op(4'd5, 4'd2, 1'b0, rd, rb, rovf, lat);
    check("post_rst_latency", 32'(lat), 32'(W + 1));
    check("post_rst_d_result", 32'(rd), 32'd3);
    check("post_rst_bout", 32'(rb), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
